// File: rtl/qspi_rom_reader.sv
// Quad-SPI read initiator: fetches single bytes from a QSPI ROM, keeping the ROM
// selected across sequential addresses so linear fetches skip command/address.
module qspi_rom_reader #(
  parameter logic [7:0] CMD     = 8'hEB,
  parameter int         ADDR_W  = 24,
  parameter int         DUMMY   = 4,
  parameter int         CS_HIGH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              spi_select,
  output logic              spi_clk,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  input  logic [3:0]        spi_io_in
);

  typedef enum logic [2:0] {
    S_DESEL, S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STREAM
  } state_t;

  localparam logic [7:0]        NIB_LAST   = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY - 1);
  localparam logic [7:0]        CS_LAST    = 8'(CS_HIGH - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_t              state, state_n;
  logic                phase, phase_n;     // 0 = L half (spi_clk low), 1 = H half
  logic [7:0]          cnt, cnt_n;
  logic [ADDR_W-1:0]   addr, addr_n;       // doubles as last fetched address in STREAM
  logic                pend, pend_n;       // latched non-sequential request awaiting issue
  logic [7:0]          shift, shift_n;
  logic                rd_valid_n, req_ready_n, spi_select_n, spi_clk_n;
  logic [7:0]          rd_data_n;
  logic [3:0]          spi_io_out_n, spi_io_oe_n;
  logic [ADDR_W-1:0]   addr_sh;
  logic                accept;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    addr_n     = addr;
    pend_n     = pend;
    shift_n    = shift;
    rd_valid_n = 1'b0;
    rd_data_n  = rd_data;
    accept     = req_valid && req_ready;

    unique case (state)
      S_DESEL: begin
        if (cnt == CS_LAST) begin
          cnt_n   = '0;
          phase_n = 1'b0;
          pend_n  = 1'b0;
          // A latched request skips IDLE so select is high for exactly CS_HIGH cycles.
          state_n = pend ? S_CMD : S_IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          addr_n  = req_addr;
          cnt_n   = '0;
          phase_n = 1'b0;
          state_n = S_CMD;
        end
      end
      S_CMD: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (cnt == 8'd1) begin
            cnt_n   = '0;
            state_n = S_ADDR;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_ADDR: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (cnt == NIB_LAST) begin
            cnt_n   = '0;
            state_n = (DUMMY == 0) ? S_DATA : S_DUMMY;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_DUMMY: begin
        if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (cnt == DUMMY_LAST) begin
            cnt_n   = '0;
            state_n = S_DATA;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (cnt == 8'd2) begin
          // Both nibbles captured; publish the byte one cycle after the last sample.
          rd_valid_n = 1'b1;
          rd_data_n  = shift;
          cnt_n      = '0;
          state_n    = S_STREAM;
        end else if (!phase) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          shift_n = {shift[3:0], spi_io_in};
          cnt_n   = cnt + 8'd1;
        end
      end
      S_STREAM: begin
        if (accept) begin
          addr_n  = req_addr;
          cnt_n   = '0;
          phase_n = 1'b0;
          if (req_addr == addr + ONE) begin
            state_n = S_DATA;
          end else begin
            pend_n  = 1'b1;
            state_n = S_DESEL;
          end
        end
      end
      default: state_n = S_DESEL;
    endcase

    // Registered outputs are derived from the next state, so they change only
    // on entry to an L half and hold through the following H half.
    addr_sh      = addr_n << {cnt_n, 2'b00};
    spi_select_n = !(state_n inside {S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STREAM});
    spi_clk_n    = phase_n && (state_n inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
    spi_io_oe_n  = (state_n inside {S_CMD, S_ADDR}) ? 4'hF : 4'h0;
    req_ready_n  = state_n inside {S_IDLE, S_STREAM};
    spi_io_out_n = 4'h0;
    if (state_n == S_CMD)  spi_io_out_n = cnt_n[0] ? CMD[3:0] : CMD[7:4];
    if (state_n == S_ADDR) spi_io_out_n = addr_sh[ADDR_W-1 -: 4];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_DESEL;
      phase      <= 1'b0;
      cnt        <= '0;
      addr       <= '0;
      pend       <= 1'b0;
      shift      <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      req_ready  <= 1'b0;
      spi_select <= 1'b1;
      spi_clk    <= 1'b0;
      spi_io_out <= '0;
      spi_io_oe  <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      addr       <= addr_n;
      pend       <= pend_n;
      shift      <= shift_n;
      rd_valid   <= rd_valid_n;
      rd_data    <= rd_data_n;
      req_ready  <= req_ready_n;
      spi_select <= spi_select_n;
      spi_clk    <= spi_clk_n;
      spi_io_out <= spi_io_out_n;
      spi_io_oe  <= spi_io_oe_n;
    end
  end

endmodule

// File: tb/tb_qspi_rom_reader.sv
// Bench for qspi_rom_reader: a default build and a DUMMY=0/CS_HIGH=1 build, each
// driven against a behavioural QSPI ROM emulator and a transaction-level model.
module tb_qspi_rom_reader;
  localparam int AW = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2] = '{1'b0, 1'b0};
  logic [23:0] req_addr  [2] = '{24'h0, 24'h0};
  logic        req_ready [2];
  logic        rd_valid  [2];
  logic [7:0]  rd_data   [2];
  logic        sel       [2];
  logic        sclk      [2];
  logic [3:0]  io_out    [2];
  logic [3:0]  io_oe     [2];
  logic [3:0]  io_in     [2] = '{4'h0, 4'h0};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qspi_rom_reader #(.DUMMY(4), .CS_HIGH(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_ready(req_ready[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .spi_select(sel[0]), .spi_clk(sclk[0]), .spi_io_out(io_out[0]),
    .spi_io_oe(io_oe[0]), .spi_io_in(io_in[0]));

  qspi_rom_reader #(.DUMMY(0), .CS_HIGH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_ready(req_ready[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .spi_select(sel[1]), .spi_clk(sclk[1]), .spi_io_out(io_out[1]),
    .spi_io_oe(io_oe[1]), .spi_io_in(io_in[1]));

  function automatic int dummy_of(int g);   return (g == 0) ? 4 : 0; endfunction
  function automatic int cs_high_of(int g); return (g == 0) ? 2 : 1; endfunction
  function automatic int full_lat(int g);   return 2 * (2 + AW / 4 + dummy_of(g) + 2) + 1; endfunction

  function automatic logic [7:0] rom_byte(logic [23:0] a);
    case (a)
      24'h000123: return 8'hA5;
      24'h000010: return 8'h01;
      24'h000011: return 8'h02;
      24'h000012: return 8'h03;
      24'h000007: return 8'h5A;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endcase
  endfunction

  // ROM emulator and bus monitor: counts SPI cycles from each select fall,
  // assembles the address, and serves ROM nibbles for every data cycle.
  int          ecnt      [2] = '{0, 0};
  logic [23:0] eaddr     [2] = '{24'h0, 24'h0};
  logic        prev_sel  [2] = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  int          sel_rise  [2] = '{0, 0};
  int          rv_cnt    [2] = '{0, 0};
  logic [7:0]  elog [$];

  always @(negedge clk) begin
    int j;
    logic [7:0] b;
    for (int g = 0; g < 2; g++) begin
      if (prev_sel[g] === 1'b0 && sel[g] === 1'b1) sel_rise[g]++;
      if (prev_sel[g] === 1'b1 && sel[g] === 1'b0) begin
        ecnt[g]  = 0;
        eaddr[g] = '0;
      end
      if (rd_valid[g] === 1'b1) rv_cnt[g]++;
      if (sel[g] === 1'b0 && sclk[g] === 1'b1 && prev_sclk[g] === 1'b0) begin
        ecnt[g]++;
        if (g == 0) elog.push_back({io_oe[g], io_out[g]});
        if (ecnt[g] >= 3 && ecnt[g] <= 8) eaddr[g] = {eaddr[g][19:0], io_out[g]};
        if (ecnt[g] > 8 + dummy_of(g)) begin
          j = ecnt[g] - 9 - dummy_of(g);
          b = rom_byte(eaddr[g] + 24'(j / 2));
          io_in[g] = (j % 2 == 1) ? b[3:0] : b[7:4];
        end else begin
          io_in[g] = 4'($urandom);
        end
      end
      prev_sel[g]  = sel[g];
      prev_sclk[g] = sclk[g];
    end
  end

  // Transaction-level reference: latency depends only on whether the ROM is
  // already streaming and whether the address continues the previous one.
  bit          streaming [2] = '{1'b0, 1'b0};
  logic [23:0] last      [2] = '{24'h0, 24'h0};

  task automatic predict(input int g, input logic [23:0] a,
                         output int lat, output int hi, output logic [7:0] d);
    if (streaming[g] && a == last[g] + 24'd1) begin
      lat = 5;  hi = 0;
    end else if (streaming[g]) begin
      hi = cs_high_of(g);  lat = hi + full_lat(g);
    end else begin
      hi = 0;  lat = full_lat(g);
    end
    d = rom_byte(a);
    streaming[g] = 1'b1;
    last[g] = a;
  endtask

  task automatic issue(input int g, input logic [23:0] a, output bit ok);
    @(negedge clk);
    req_valid[g] = 1'b1;
    req_addr[g]  = a;
    for (int k = 0; k < 200 && req_ready[g] !== 1'b1; k++) @(negedge clk);
    ok = (req_ready[g] === 1'b1);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept dut%0d addr %h: req_ready stayed low", g, a);
      req_valid[g] = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Counts edges from the accept edge until rd_valid, and select-high cycles on the way.
  task automatic wait_rd(input int g, input int budget, output int lat, output int hi);
    lat = -1;
    hi  = 0;
    @(negedge clk);
    req_valid[g] = 1'b0;
    if (sel[g] === 1'b1) hi++;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (rd_valid[g] === 1'b1) begin
        lat = n;
        break;
      end
      if (sel[g] === 1'b1) hi++;
    end
  endtask

  task automatic do_read(input int g, input logic [23:0] a,
                         output int lat, output int hi, output logic [7:0] d);
    bit ok;
    lat = -1;  hi = -1;  d = 'x;
    issue(g, a, ok);
    if (ok) begin
      wait_rd(g, 80, lat, hi);
      d = rd_data[g];
    end
  endtask

  task automatic test_reset();
    int rdy_at [2];
    @(negedge clk);
    vectors++;
    if ({sel[0], sclk[0], io_out[0], io_oe[0], rd_valid[0], rd_data[0], req_ready[0]} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: sel=%b sclk=%b out=%h oe=%h rv=%b data=%h rdy=%b, required 1 0 0 0 0 00 0",
               sel[0], sclk[0], io_out[0], io_oe[0], rd_valid[0], rd_data[0], req_ready[0]);
    end
    rst_n = 1'b1;
    rdy_at = '{-1, -1};
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) if (rdy_at[g] < 0 && req_ready[g] === 1'b1) rdy_at[g] = n;
    end
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if (rdy_at[g] !== cs_high_of(g)) begin
        miscompares++;
        $display("FAIL reset_desel dut%0d: req_ready after %0d cycles, required %0d", g, rdy_at[g], cs_high_of(g));
      end
    end
  endtask

  task automatic test_single();
    int l, h, el, eh;
    logic [7:0] d, ed;
    logic [3:0] exp_nib [8];
    exp_nib = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3};
    elog.delete();
    predict(0, 24'h000123, el, eh, ed);
    do_read(0, 24'h000123, l, h, d);
    vectors++; if (l !== el) begin miscompares++; $display("FAIL single_latency: %0d, required %0d", l, el); end
    vectors++; if (d !== ed) begin miscompares++; $display("FAIL single_data: %h, required %h", d, ed); end
    vectors++;
    if ({sel[0], req_ready[0], sclk[0]} !== 3'b010) begin
      miscompares++;
      $display("FAIL single_stream_entry: sel/ready/sclk=%b%b%b, required 010", sel[0], req_ready[0], sclk[0]);
    end
    vectors++;
    if (elog.size() != 14) begin miscompares++; $display("FAIL single_spi_cycles: %0d, required 14", elog.size()); end
    for (int k = 0; k < 14 && k < elog.size(); k++) begin
      vectors++;
      if (k < 8 && elog[k] !== {4'hF, exp_nib[k]}) begin
        miscompares++;
        $display("FAIL single_nibble[%0d]: oe/io=%h, required F%h", k, elog[k], exp_nib[k]);
      end else if (k >= 8 && elog[k][7:4] !== 4'h0) begin
        miscompares++;
        $display("FAIL single_oe[%0d]: oe=%h, required 0", k, elog[k][7:4]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({rd_valid[0], rd_data[0]} !== {1'b0, ed}) begin
      miscompares++;
      $display("FAIL single_pulse_hold: rv=%b data=%h, required 0 %h", rd_valid[0], rd_data[0], ed);
    end
  endtask

  task automatic test_stream();
    int l, h, el, eh, rise0;
    logic [7:0] d, ed;
    logic [23:0] a;
    predict(0, 24'h10, el, eh, ed);
    do_read(0, 24'h10, l, h, d);
    vectors++; if ({l, d} !== {el, ed}) begin miscompares++; $display("FAIL stream_first: lat=%0d data=%h, required %0d %h", l, d, el, ed); end
    rise0 = sel_rise[0];
    elog.delete();
    for (int k = 1; k <= 2; k++) begin
      a = 24'h10 + 24'(k);
      predict(0, a, el, eh, ed);
      do_read(0, a, l, h, d);
      vectors++; if (l !== el) begin miscompares++; $display("FAIL stream_latency %h: %0d, required %0d", a, l, el); end
      vectors++; if (d !== ed) begin miscompares++; $display("FAIL stream_data %h: %h, required %h", a, d, ed); end
    end
    vectors++; if (sel_rise[0] !== rise0) begin miscompares++; $display("FAIL stream_select: %0d deselects, required 0", sel_rise[0] - rise0); end
    vectors++;
    if (elog.size() != 4 || elog[0][7:4] !== 4'h0 || elog[3][7:4] !== 4'h0) begin
      miscompares++;
      $display("FAIL stream_no_cmd: %0d spi cycles, required 4 input-only", elog.size());
    end
  endtask

  task automatic test_nonseq();
    int l, h, el, eh, rise0;
    logic [7:0] d, ed;
    logic [3:0] exp_nib [8];
    exp_nib = '{4'hE, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
    rise0 = sel_rise[0];
    elog.delete();
    predict(0, 24'h40, el, eh, ed);
    do_read(0, 24'h40, l, h, d);
    vectors++; if (h !== eh) begin miscompares++; $display("FAIL nonseq_select_high: %0d cycles, required %0d", h, eh); end
    vectors++; if (l !== el) begin miscompares++; $display("FAIL nonseq_latency: %0d, required %0d", l, el); end
    vectors++; if (d !== ed) begin miscompares++; $display("FAIL nonseq_data: %h, required %h", d, ed); end
    vectors++; if (sel_rise[0] !== rise0 + 1) begin miscompares++; $display("FAIL nonseq_deselects: %0d, required 1", sel_rise[0] - rise0); end
    for (int k = 0; k < 8 && k < elog.size(); k++) begin
      vectors++;
      if (elog[k] !== {4'hF, exp_nib[k]}) begin
        miscompares++;
        $display("FAIL nonseq_nibble[%0d]: oe/io=%h, required F%h", k, elog[k], exp_nib[k]);
      end
    end
  endtask

  task automatic test_wrap();
    int l, h, el, eh, rise0;
    logic [7:0] d, ed;
    predict(0, 24'hFFFFFF, el, eh, ed);
    do_read(0, 24'hFFFFFF, l, h, d);
    vectors++; if ({l, d} !== {el, ed}) begin miscompares++; $display("FAIL wrap_first: lat=%0d data=%h, required %0d %h", l, d, el, ed); end
    rise0 = sel_rise[0];
    predict(0, 24'h000000, el, eh, ed);
    do_read(0, 24'h000000, l, h, d);
    vectors++; if (l !== el) begin miscompares++; $display("FAIL wrap_latency: %0d, required %0d", l, el); end
    vectors++; if (d !== ed) begin miscompares++; $display("FAIL wrap_data: %h, required %h", d, ed); end
    vectors++; if (sel_rise[0] !== rise0) begin miscompares++; $display("FAIL wrap_select: deselected %0d times, required 0", sel_rise[0] - rise0); end
  endtask

  // The second request is held from the moment the first is accepted; it must
  // wait, unchanged, until the reader is back in STREAM.
  task automatic test_back_to_back();
    int l1, h1, l2, h2, first, second;
    logic [7:0] d1, d2, got1, got2;
    bit ok;
    first = -1;  second = -1;  got1 = 'x;  got2 = 'x;
    predict(0, 24'h500, l1, h1, d1);
    predict(0, 24'h501, l2, h2, d2);
    issue(0, 24'h500, ok);
    if (!ok) return;
    @(negedge clk);
    req_addr[0] = 24'h501;
    for (int n = 1; n <= 120 && second < 0; n++) begin
      @(negedge clk);
      if (first > 0 && n == first + 1) req_valid[0] = 1'b0;
      if (rd_valid[0] === 1'b1) begin
        if (first < 0) begin first = n; got1 = rd_data[0]; end
        else begin second = n; got2 = rd_data[0]; end
      end
    end
    req_valid[0] = 1'b0;
    vectors++; if (first !== l1) begin miscompares++; $display("FAIL b2b_first_latency: %0d, required %0d", first, l1); end
    vectors++; if (got1 !== d1) begin miscompares++; $display("FAIL b2b_first_data: %h, required %h", got1, d1); end
    vectors++; if (second !== l1 + 1 + l2) begin miscompares++; $display("FAIL b2b_second_latency: %0d, required %0d", second, l1 + 1 + l2); end
    vectors++; if (got2 !== d2) begin miscompares++; $display("FAIL b2b_second_data: %h, required %h", got2, d2); end
  endtask

  task automatic test_random();
    int l, h, el, eh;
    logic [7:0] d, ed;
    logic [23:0] a;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 1) == 1) ? last[0] + 24'd1 : 24'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      predict(0, a, el, eh, ed);
      do_read(0, a, l, h, d);
      vectors++;
      if ({l, h, d} !== {el, eh, ed}) begin
        miscompares++;
        $display("FAIL random[%0d] addr %h: lat=%0d hi=%0d data=%h, required %0d %0d %h", i, a, l, h, d, el, eh, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rv0, rdy_at;
    bit ok;
    elog.delete();
    issue(0, 24'h000234, ok);
    if (!ok) return;
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 100 && elog.size() < 7; k++) begin
      @(negedge clk);
      #1;
    end
    vectors++; if (elog.size() < 7) begin miscompares++; $display("FAIL rstmid_reach_addr: %0d spi cycles, required 7", elog.size()); end
    rv0 = rv_cnt[0];
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sel[0], io_oe[0], sclk[0]} !== {1'b1, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_async: sel=%b oe=%h sclk=%b, required 1 0 0", sel[0], io_oe[0], sclk[0]);
    end
    streaming = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_at = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rdy_at < 0 && req_ready[0] === 1'b1) rdy_at = n;
    end
    vectors++; if (rdy_at !== cs_high_of(0)) begin miscompares++; $display("FAIL rstmid_desel: ready after %0d, required %0d", rdy_at, cs_high_of(0)); end
    vectors++;
    if (rv_cnt[0] !== rv0 || rd_data[0] !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid_no_byte: %0d rd_valid pulses, data=%h, required 0 and 00", rv_cnt[0] - rv0, rd_data[0]);
    end
  endtask

  task automatic test_dummy0();
    int l, h, el, eh;
    logic [7:0] d, ed;
    logic [23:0] addrs [3];
    addrs = '{24'h000007, 24'h000030, 24'h000031};
    for (int i = 0; i < 3; i++) begin
      predict(1, addrs[i], el, eh, ed);
      do_read(1, addrs[i], l, h, d);
      vectors++; if (l !== el) begin miscompares++; $display("FAIL dummy0_latency %h: %0d, required %0d", addrs[i], l, el); end
      vectors++; if (d !== ed) begin miscompares++; $display("FAIL dummy0_data %h: %h, required %h", addrs[i], d, ed); end
      vectors++; if (h !== eh) begin miscompares++; $display("FAIL dummy0_select_high %h: %0d, required %0d", addrs[i], h, eh); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_nonseq();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_dummy0();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
